// File: rtl/fetcher_pkg.sv
// Shared opcodes, default geometry, FSM encoding and RISC-V immediate decoders
// for the instruction-fetch stage.
package fetcher_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int ICACHE_IDX_W_DEF = 6;
    localparam int BHT_IDX_W_DEF    = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetcher_icache.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup,
// single-cycle fill; addresses are word addresses (byte pc >> 2).
module fetcher_icache #(
    parameter int IDX_W = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [29:0] i_lookup_wa,
    output logic        o_hit,
    output logic [31:0] o_data,
    input  logic        i_fill_en,
    input  logic [29:0] i_fill_wa,
    input  logic [31:0] i_fill_data
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_fill_idx;
    logic             w_fill;

    assign w_lk_idx   = i_lookup_wa[IDX_W-1:0];
    assign w_lk_tag   = i_lookup_wa[29:IDX_W];
    assign w_fill_idx = i_fill_wa[IDX_W-1:0];
    assign w_fill     = i_en && i_fill_en;

    assign o_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign o_data = r_data[w_lk_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    // Payload arrays need no reset: a line is only read once its valid bit is set.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_fill) begin
            r_tag[w_fill_idx]  <= i_fill_wa[29:IDX_W];
            r_data[w_fill_idx] <= i_fill_data;
        end
    end

endmodule

// File: rtl/fetcher.sv
// Fetch stage: PC, icache, static/BHT branch prediction, one issue per cycle.
// Issue is registered (visible the cycle after an IDLE hit); full_from_backend holds issue.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int ICACHE_IDX_W = ICACHE_IDX_W_DEF,
    parameter int BHT_IDX_W    = BHT_IDX_W_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic [31:0] pc_to_dispatcher,
    output logic [31:0] inst_to_dispatcher,
    output logic [31:0] rollback_pc_to_dispatcher,
    output logic        predicted_jump_to_dispatcher,
    output logic        ok_flag_to_dispatcher,
    input  logic        full_from_backend,
    output logic        mem_en_to_memctrl,
    output logic [31:0] mem_addr_to_memctrl,
    input  logic        mem_valid_from_memctrl,
    input  logic [31:0] mem_data_from_memctrl,
    input  logic        rollback_flag_from_rob,
    input  logic [31:0] rollback_pc_from_rob,
    input  logic        bht_en_from_rob,
    input  logic [31:0] bht_pc_from_rob,
    input  logic        bht_taken_from_rob
);
    localparam int BHT_N = 1 << BHT_IDX_W;

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_pc_out;
    logic [31:0]  r_inst_out;
    logic [31:0]  r_rb_out;
    logic         r_pred_out;
    logic         r_ok;
    logic         r_mem_en;
    logic [31:0]  r_mem_addr;
    logic [1:0]   r_bht [BHT_N];

    logic                 w_hit;
    logic [31:0]          w_word;
    logic                 w_fill_en;
    logic [BHT_IDX_W-1:0] w_bht_rd_idx;
    logic [BHT_IDX_W-1:0] w_bht_wr_idx;
    logic [1:0]           w_bht_old;
    logic [31:0]          w_pc_plus4;
    logic [31:0]          w_pc_jal;
    logic [31:0]          w_pc_br;
    logic                 w_pred;
    logic [31:0]          w_next_pc;
    logic [31:0]          w_rb_pc;
    logic                 w_unused_bht_pc;

    assign w_fill_en = (r_state == WAIT) && mem_valid_from_memctrl && !rollback_flag_from_rob;

    fetcher_icache #(
        .IDX_W (ICACHE_IDX_W)
    ) u_icache (
        .i_clk       (clk_in),
        .i_rst       (rst_in),
        .i_en        (rdy_in),
        .i_lookup_wa (r_pc[31:2]),
        .o_hit       (w_hit),
        .o_data      (w_word),
        .i_fill_en   (w_fill_en),
        .i_fill_wa   (r_pc[31:2]),
        .i_fill_data (mem_data_from_memctrl)
    );

    assign w_bht_rd_idx    = r_pc[BHT_IDX_W+1:2];
    assign w_bht_wr_idx    = bht_pc_from_rob[BHT_IDX_W+1:2];
    assign w_bht_old       = r_bht[w_bht_wr_idx];
    assign w_unused_bht_pc = ^{bht_pc_from_rob[31:BHT_IDX_W+2], bht_pc_from_rob[1:0]};

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_jal   = r_pc + imm_j(w_word);
    assign w_pc_br    = r_pc + imm_b(w_word);

    // Rollback pc is always the path not followed, so the RoB can redirect in one step.
    always_comb begin
        w_pred    = 1'b0;
        w_next_pc = w_pc_plus4;
        w_rb_pc   = w_pc_plus4;
        case (w_word[6:0])
            OPC_JAL: begin
                w_pred    = 1'b1;
                w_next_pc = w_pc_jal;
            end
            OPC_BRANCH: begin
                if (r_bht[w_bht_rd_idx][1]) begin
                    w_pred    = 1'b1;
                    w_next_pc = w_pc_br;
                end else begin
                    w_rb_pc = w_pc_br;
                end
            end
            OPC_JALR: w_pred = 1'b0;
            default:  w_pred = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_pc_out   <= '0;
            r_inst_out <= '0;
            r_rb_out   <= '0;
            r_pred_out <= 1'b0;
            r_ok       <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
        end else if (rdy_in) begin
            r_ok <= 1'b0;
            if (rollback_flag_from_rob) begin
                r_pc     <= rollback_pc_from_rob;
                r_mem_en <= 1'b0;
                r_state  <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_hit) begin
                            if (!full_from_backend) begin
                                r_ok       <= 1'b1;
                                r_pc_out   <= r_pc;
                                r_inst_out <= w_word;
                                r_pred_out <= w_pred;
                                r_rb_out   <= w_rb_pc;
                                r_pc       <= w_next_pc;
                            end
                        end else begin
                            r_mem_addr <= {r_pc[31:2], 2'b00};
                            r_mem_en   <= 1'b1;
                            r_state    <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (mem_valid_from_memctrl) begin
                            r_mem_en <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // BHT trains on every commit, independent of fetch state; reads see the old value.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < BHT_N; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (rdy_in && bht_en_from_rob) begin
            if (bht_taken_from_rob) begin
                if (w_bht_old != 2'b11) r_bht[w_bht_wr_idx] <= w_bht_old + 2'b01;
            end else begin
                if (w_bht_old != 2'b00) r_bht[w_bht_wr_idx] <= w_bht_old - 2'b01;
            end
        end
    end

    assign pc_to_dispatcher             = r_pc_out;
    assign inst_to_dispatcher           = r_inst_out;
    assign rollback_pc_to_dispatcher    = r_rb_out;
    assign predicted_jump_to_dispatcher = r_pred_out;
    assign ok_flag_to_dispatcher        = r_ok;
    assign mem_en_to_memctrl            = r_mem_en;
    assign mem_addr_to_memctrl          = r_mem_addr;

endmodule

// File: tb/tb_fetcher.sv
// Scoreboarded bench for fetcher: stimulus pushes expected issues, a monitor
// pops and compares on every ok_flag pulse; a memory model answers misses.
module tb_fetcher;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] JAL  = 32'h0100006F;
    localparam logic [31:0] BEQ  = 32'h00000663;
    localparam logic [31:0] JALR = 32'h00008067;
    localparam logic [31:0] BNEG = 32'hFE000EE3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
        logic [31:0] rb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] pc_o, inst_o, rb_o;
    logic        pred_o, ok_o;
    logic        full = 1'b1;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = '0;
    logic        rb_flag = 1'b0;
    logic [31:0] rb_pc = '0;
    logic        bht_en = 1'b0;
    logic [31:0] bht_pc = '0;
    logic        bht_tk = 1'b0;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [31:0] mem [logic [31:0]];
    bit auto_mem = 1'b0;
    int lat_dummy;

    always #5 clk = ~clk;

    fetcher dut (
        .clk_in                       (clk),
        .rst_in                       (rst),
        .rdy_in                       (rdy),
        .pc_to_dispatcher             (pc_o),
        .inst_to_dispatcher           (inst_o),
        .rollback_pc_to_dispatcher    (rb_o),
        .predicted_jump_to_dispatcher (pred_o),
        .ok_flag_to_dispatcher        (ok_o),
        .full_from_backend            (full),
        .mem_en_to_memctrl            (mem_en),
        .mem_addr_to_memctrl          (mem_addr),
        .mem_valid_from_memctrl       (mem_valid),
        .mem_data_from_memctrl        (mem_data),
        .rollback_flag_from_rob       (rb_flag),
        .rollback_pc_from_rob         (rb_pc),
        .bht_en_from_rob              (bht_en),
        .bht_pc_from_rob              (bht_pc),
        .bht_taken_from_rob           (bht_tk)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return NOP;
    endfunction

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                input logic pred, input logic [31:0] rb);
        exp_t e;
        e.pc = pc; e.inst = inst; e.pred = pred; e.rb = rb;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory controller model: answers a level request after two cycles.
    initial begin
        int lat = 0;
        forever begin
            @(negedge clk);
            if (!auto_mem) begin
                lat = 0;
            end else if (mem_valid) begin
                mem_valid = 1'b0;
                lat = 0;
            end else if (mem_en) begin
                lat++;
                if (lat >= 2) begin
                    mem_valid = 1'b1;
                    mem_data  = mem_rd(mem_addr);
                    lat = 0;
                end
            end else begin
                lat = 0;
            end
        end
    end

    // Monitor: every ok_flag pulse must match the oldest expected issue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ok_o) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue: got pc=%h inst=%h, expected no issue", pc_o, inst_o);
                end else begin
                    e = sb.pop_front();
                    if (pc_o !== e.pc || inst_o !== e.inst || pred_o !== e.pred || rb_o !== e.rb) begin
                        errors++;
                        $display("FAIL issue: got pc=%h inst=%h pred=%b rb=%h, expected pc=%h inst=%h pred=%b rb=%h",
                                 pc_o, inst_o, pred_o, rb_o, e.pc, e.inst, e.pred, e.rb);
                    end
                end
            end
        end
    end

    task automatic set_manual();
        auto_mem  = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic do_reset();
        set_manual();
        rst = 1'b1; full = 1'b1; rb_flag = 1'b0; bht_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rollback(input logic [31:0] pc);
        rb_flag = 1'b1; rb_pc = pc;
        @(negedge clk);
        rb_flag = 1'b0;
    endtask

    task automatic bht_upd(input logic tk);
        bht_en = 1'b1; bht_pc = 32'd8; bht_tk = tk;
        @(negedge clk);
        bht_en = 1'b0;
    endtask

    // Release backpressure until exactly one issue is seen, then reassert it.
    task automatic fetch_one(input exp_t e, output int lat);
        sb.push_back(e);
        full = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ok_o && lat < 200);
        full = 1'b1;
        if (!ok_o) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got no ok_flag, expected pc=%h", e.pc);
        end
    endtask

    task automatic wait_mem_en(input logic val);
        int n = 0;
        while (mem_en !== val && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_mem_en", {31'd0, mem_en}, {31'd0, val});
    endtask

    initial begin
        int lat;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ok", {31'd0, ok_o}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_pc_out", pc_o, 32'd0);
        chk("rst_inst_out", inst_o, 32'd0);
        chk("rst_rb_out", rb_o, 32'd0);
        chk("rst_pred_out", {31'd0, pred_o}, 32'd0);
        rst = 1'b0;

        // Cold start: miss on 0, fill, issue nop, next request at 4
        mem[32'h0] = NOP;
        @(negedge clk);
        chk("cold_mem_en", {31'd0, mem_en}, 32'd1);
        chk("cold_mem_addr", mem_addr, 32'd0);
        auto_mem = 1'b1;
        fetch_one(mk(32'h0, NOP, 1'b0, 32'h4), lat_dummy);
        @(negedge clk);
        chk("next_mem_en", {31'd0, mem_en}, 32'd1);
        chk("next_mem_addr", mem_addr, 32'h4);

        // JAL +16, cold then warm
        do_reset();
        mem[32'h0] = JAL;
        mem[32'h14] = JALR;
        mem[32'h8] = BEQ;
        auto_mem = 1'b1;
        fetch_one(mk(32'h0, JAL, 1'b1, 32'h4), lat_dummy);
        fetch_one(mk(32'h10, NOP, 1'b0, 32'h14), lat_dummy);
        rollback(32'h0);
        fetch_one(mk(32'h0, JAL, 1'b1, 32'h4), lat_dummy);

        // BEQ +12 at 8: weakly not-taken, then trained taken (one update in a rollback cycle)
        rollback(32'h8);
        fetch_one(mk(32'h8, BEQ, 1'b0, 32'h14), lat_dummy);
        rb_flag = 1'b1; rb_pc = 32'h8;
        bht_en = 1'b1; bht_pc = 32'h8; bht_tk = 1'b1;
        @(negedge clk);
        rb_flag = 1'b0;
        @(negedge clk);
        bht_en = 1'b0;
        fetch_one(mk(32'h8, BEQ, 1'b1, 32'hC), lat_dummy);
        fetch_one(mk(32'h14, JALR, 1'b0, 32'h18), lat_dummy);
        // Saturation at 3, then at 0
        bht_upd(1'b1);
        bht_upd(1'b0);
        rollback(32'h8);
        fetch_one(mk(32'h8, BEQ, 1'b1, 32'hC), lat_dummy);
        repeat (4) bht_upd(1'b0);
        bht_upd(1'b1);
        rollback(32'h8);
        fetch_one(mk(32'h8, BEQ, 1'b0, 32'h14), lat_dummy);

        // Rollback coinciding with mem_valid drops the fill
        set_manual();
        rollback(32'h80);
        wait_mem_en(1'b1);
        chk("wait_addr_80", mem_addr, 32'h80);
        mem_valid = 1'b1; mem_data = NOP;
        rb_flag = 1'b1; rb_pc = 32'h40;
        @(negedge clk);
        mem_valid = 1'b0; rb_flag = 1'b0;
        chk("rb_mem_en_drop", {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        chk("rb_mem_en", {31'd0, mem_en}, 32'd1);
        chk("rb_mem_addr", mem_addr, 32'h40);
        auto_mem = 1'b1;
        wait_mem_en(1'b0);
        rollback(32'h80);
        @(negedge clk);
        chk("nofill_mem_en", {31'd0, mem_en}, 32'd1);
        chk("nofill_mem_addr", mem_addr, 32'h80);
        fetch_one(mk(32'h80, NOP, 1'b0, 32'h84), lat_dummy);

        // Warm hit held by full for 3 cycles, then a single issue
        rollback(32'h80);
        repeat (3) begin
            @(negedge clk);
            chk("full_ok", {31'd0, ok_o}, 32'd0);
            chk("full_mem_en", {31'd0, mem_en}, 32'd0);
        end
        fetch_one(mk(32'h80, NOP, 1'b0, 32'h84), lat);
        chk("full_release_latency", lat, 32'd1);

        // rdy low mid-WAIT freezes fetch and BHT
        set_manual();
        rollback(32'hC0);
        wait_mem_en(1'b1);
        chk("rdy_addr", mem_addr, 32'hC0);
        rdy = 1'b0;
        bht_en = 1'b1; bht_pc = 32'hC0; bht_tk = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("frozen_mem_en", {31'd0, mem_en}, 32'd1);
            chk("frozen_mem_addr", mem_addr, 32'hC0);
        end
        bht_en = 1'b0;
        rdy = 1'b1;
        mem_valid = 1'b1; mem_data = BNEG;
        @(negedge clk);
        mem_valid = 1'b0;
        fetch_one(mk(32'hC0, BNEG, 1'b0, 32'hBC), lat_dummy);
        @(negedge clk);
        chk("after_rdy_mem_en", {31'd0, mem_en}, 32'd1);
        chk("after_rdy_addr", mem_addr, 32'hC4);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetcher.md
Name: fetcher

Overview:
- Instruction-fetch stage of the Tomasulo core; sits directly upstream of the dispatcher.
- Holds the PC and a direct-mapped instruction cache, and requests misses from the memory controller.
- Predicts control flow: JAL always taken, B-type via a 2-bit BHT, JALR not taken.
- Emits at most one instruction per cycle with pc, predicted_jump and rollback_pc. Redirects on RoB rollback and trains the BHT from RoB commits.

Parameters:
ICACHE_IDX_W, 6, index bits; ICACHE has 2^ICACHE_IDX_W one-word lines, tag = pc[31:ICACHE_IDX_W+2]
BHT_IDX_W, 8, BHT index bits; 2^BHT_IDX_W 2-bit counters indexed by pc[BHT_IDX_W+1:2]

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; when low all state is frozen
pc_to_dispatcher  output  32  pc of issued instruction
inst_to_dispatcher  output  32  instruction word
rollback_pc_to_dispatcher  output  32  pc to resume at if prediction is wrong
predicted_jump_to_dispatcher  output  1  1 = fetch followed the taken path
ok_flag_to_dispatcher  output  1  one-cycle pulse: outputs above are valid
full_from_backend  input  1  OR of RoB/RS/LSB full; no issue while high
mem_en_to_memctrl  output  1  level request for word at mem_addr_to_memctrl
mem_addr_to_memctrl  output  32  word-aligned fetch address
mem_valid_from_memctrl  input  1  one-cycle pulse: mem_data valid
mem_data_from_memctrl  input  32  fetched word
rollback_flag_from_rob  input  1  mispredict flush
rollback_pc_from_rob  input  32  correct next pc
bht_en_from_rob  input  1  commit of a B-type instruction
bht_pc_from_rob  input  32  pc of that branch
bht_taken_from_rob  input  1  actual outcome

Behaviour:
- Reset: pc=0, state=IDLE, all icache valid bits 0, all BHT counters 2'b01, ok_flag=0, mem_en=0, all other outputs 0.
- rdy_in low: no register changes, including icache, BHT and FSM.
- FSM states:
  - IDLE: icache lookup on pc.
    - Hit and !full_from_backend: issue.
    - Miss: set mem_addr=pc, mem_en=1, go to WAIT.
    - Hit while full: hold; ok_flag=0.
  - WAIT: mem_en held at 1.
    - On mem_valid: write data/tag/valid into line pc[ICACHE_IDX_W+1:2], mem_en=0, return to IDLE.
    - The instruction issues on a later IDLE hit; no bypass.
- Issue (registered, visible the cycle after the IDLE hit): ok_flag=1, pc_to_dispatcher=pc, inst_to_dispatcher=word. Next pc is chosen by opcode:
  - JAL (7'b1101111): predicted_jump=1, next pc=pc+immJ, rollback_pc=pc+4.
  - B-type (7'b1100011): counter>=2 selects predicted_jump=1, next pc=pc+immB, rollback_pc=pc+4. Otherwise predicted_jump=0, next pc=pc+4, rollback_pc=pc+immB.
  - JALR and all others: predicted_jump=0, next pc=pc+4, rollback_pc=pc+4.
  - Immediates are sign-extended; adds are 32-bit and wrap modulo 2^32.
- ok_flag is 1 for exactly one cycle per issued instruction; it is 0 in every cycle with no issue.
- Rollback has priority over everything:
  - pc=rollback_pc_from_rob, ok_flag=0 that cycle, mem_en=0, state=IDLE.
  - A mem_valid arriving in the rollback cycle is discarded with no fill.
  - The memory controller drops its in-flight request on the same flag.
- BHT update is independent of the FSM and applies on bht_en, rollback included. The counter saturates: taken increments up to 3, not-taken decrements down to 0.
- When an update and a prediction read hit the same entry in the same cycle, the read returns the old value.
- The icache never needs invalidation, because there is no self-modifying code.

Decomposition:
- Shared defines file holds OPC_JAL, OPC_JALR, OPC_BRANCH, the ICACHE_IDX_W/BHT_IDX_W defaults, and the FSM state encodings IDLE=0, WAIT=1.
- One sub-module, icache: parameterised, combinational hit/data lookup plus a synchronous fill port, with valid bits cleared on rst_in.
- BHT, immediate extraction and the FSM stay in fetcher.

Test Plan:
- Cold start, word at addr 0 = 32'h00000013 (nop) → mem_en=1, addr=0. Fill on mem_valid, then ok_flag pulse with pc=0, inst=32'h13, predicted_jump=0, rollback_pc=4. Next request is addr 4.
- Word at 0 = JAL x0,+16 (32'h0100006F), cache warm → issue pc=0, predicted_jump=1, rollback_pc=4. Next issued pc=16.
- BEQ at 8 with offset +12, BHT entry 2 at reset value 1 → predicted_jump=0, rollback_pc=20. After two bht_en taken updates for pc 8, re-fetch gives predicted_jump=1, next pc=20, rollback_pc=12.
- Miss in WAIT, then rollback_flag with rollback_pc=0x40 in the same cycle as mem_valid → no fill, no ok_flag. Next request addr=0x40.
- Warm hit while full_from_backend=1 for 3 cycles → ok_flag stays 0 and pc holds. A single issue occurs the cycle after full drops.
- rdy_in=0 for 2 cycles mid-WAIT with mem_valid low → FSM, pc and mem_en unchanged; fetch resumes normally when rdy_in returns.
